// File: rtl/share_pipe_stage_pkg.sv
// rtl/share_pipe_stage_pkg.sv - shared constants and helpers for the share pipeline
// Holds the default share geometry, the share-slice offset helper and the
// occupancy counter width function used by share_pipe_stage and its cell.
package share_pipe_stage_pkg;

    localparam int DEFAULT_WIDTH  = 64;
    localparam int DEFAULT_SHARES = 2;

    // Bit offset of share s inside a packed word of SHARES*width bits.
    function automatic int share_lo(input int s, input int width);
        return s * width;
    endfunction

    // Width needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/share_pipe_cell.sv
// rtl/share_pipe_cell.sv - one pipeline stage: valid bit, data register, load/clear control
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush          synchronous clear of valid and data (beats load)
//   load           a new word enters this stage on the next edge
//   advance        the held word leaves this stage on the next edge
//   ld_data        word to capture on load
//   v, d           registered valid bit and data word
module share_pipe_cell
    import share_pipe_stage_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SHARES = DEFAULT_SHARES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      load,
    input  logic                      advance,
    input  logic [SHARES*WIDTH-1:0]   ld_data,
    output logic                      v,
    output logic [SHARES*WIDTH-1:0]   d
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (load) begin
            v <= 1'b1;
        end else if (advance) begin
            v <= 1'b0;
        end
    end

    // One register per share so that no share's bits ever meet another's.
    // A departing word leaves its data in place; only load or clear touch it.
    for (genvar s = 0; s < SHARES; s++) begin : g_share
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d[share_lo(s, WIDTH) +: WIDTH] <= '0;
            end else if (flush) begin
                d[share_lo(s, WIDTH) +: WIDTH] <= '0;
            end else if (load) begin
                d[share_lo(s, WIDTH) +: WIDTH] <= ld_data[share_lo(s, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/share_pipe_stage.sv
// rtl/share_pipe_stage.sv - DEPTH-stage valid/ready register pipeline for Boolean-shared words
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous clear of every stage; blocks acceptance
//   in_valid/in_ready     upstream handshake, in_data share s at [s*WIDTH +: WIDTH]
//   out_valid/out_ready   downstream handshake, out_data registered from last stage
//   occupancy             number of valid stages
module share_pipe_stage
    import share_pipe_stage_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SHARES = DEFAULT_SHARES,
    parameter int DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHARES*WIDTH-1:0]       in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHARES*WIDTH-1:0]       out_data,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH:0]             r;
    logic [DEPTH-1:0]           v;
    logic [DEPTH-1:0]           load;
    logic [DEPTH-1:0]           advance;
    logic [SHARES*WIDTH-1:0]    d [DEPTH];

    // Ready ripples from the output back: a stage can take a word if it is
    // empty or its own word is leaving, so bubbles collapse under backpressure.
    always_comb begin
        r        = '0;
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r[i] = ~v[i] | r[i+1];
        end
    end

    assign in_ready = r[0] & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [SHARES*WIDTH-1:0] ld_data;

        if (i == 0) begin : g_head
            assign load[i] = in_valid & in_ready;
            assign ld_data = in_data;
        end else begin : g_body
            assign load[i] = v[i-1] & r[i];
            assign ld_data = d[i-1];
        end

        assign advance[i] = v[i] & r[i+1];

        share_pipe_cell #(
            .WIDTH  (WIDTH),
            .SHARES (SHARES)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load    (load[i]),
            .advance (advance[i]),
            .ld_data (ld_data),
            .v       (v[i]),
            .d       (d[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_share_pipe_stage.sv
// tb/tb_share_pipe_stage.sv - directed self-checking bench for share_pipe_stage
module tb_share_pipe_stage;

    logic clk;
    logic rst;

    // DEPTH=2, WIDTH=64, SHARES=2
    logic         a_flush, a_vld, a_rdy, a_ovld, a_ordy;
    logic [127:0] a_din, a_dout;
    logic [1:0]   a_occ;

    // DEPTH=3, WIDTH=16, SHARES=2
    logic         b_flush, b_vld, b_rdy, b_ovld, b_ordy;
    logic [31:0]  b_din, b_dout;
    logic [1:0]   b_occ;

    // DEPTH=2, WIDTH=8, SHARES=3
    logic         c_flush, c_vld, c_rdy, c_ovld, c_ordy;
    logic [23:0]  c_din, c_dout;
    logic [1:0]   c_occ;

    int total = 0;
    int bad   = 0;

    share_pipe_stage #(.WIDTH(64), .SHARES(2), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_vld), .in_ready(a_rdy),
        .in_data(a_din), .out_valid(a_ovld), .out_ready(a_ordy), .out_data(a_dout),
        .occupancy(a_occ)
    );

    share_pipe_stage #(.WIDTH(16), .SHARES(2), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_vld), .in_ready(b_rdy),
        .in_data(b_din), .out_valid(b_ovld), .out_ready(b_ordy), .out_data(b_dout),
        .occupancy(b_occ)
    );

    share_pipe_stage #(.WIDTH(8), .SHARES(3), .DEPTH(2)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_vld), .in_ready(c_rdy),
        .in_data(c_din), .out_valid(c_ovld), .out_ready(c_ordy), .out_data(c_dout),
        .occupancy(c_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [127:0] sw [3];
    logic [31:0]  bw [4];

    initial begin
        sw[0] = {32{4'h1}};
        sw[1] = {32{4'h2}};
        sw[2] = {32{4'h3}};
        bw[0] = 32'hAAAA_0001;
        bw[1] = 32'hBBBB_0002;
        bw[2] = 32'hCCCC_0003;
        bw[3] = 32'hDDDD_0004;

        rst = 1'b1;
        a_flush = 0; a_vld = 0; a_ordy = 0; a_din = '0;
        b_flush = 0; b_vld = 0; b_ordy = 0; b_din = '0;
        c_flush = 0; c_vld = 0; c_ordy = 0; c_din = '0;

        // reset state
        tick();
        check("rst_a_ovld", a_ovld, 0);
        check("rst_a_dout", a_dout, 0);
        check("rst_a_occ",  a_occ,  0);
        check("rst_a_rdy",  a_rdy,  1);
        check("rst_b_ovld", b_ovld, 0);
        check("rst_c_dout", c_dout, 0);
        a_flush = 1'b1;
        #1;
        check("rst_a_rdy_flush", a_rdy, 0);
        a_flush = 1'b0;
        rst = 1'b0;

        // streaming, DEPTH=2
        a_ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_vld = (k < 3);
            a_din = (k < 3) ? sw[k] : '0;
            #1;
            check("stream_rdy", a_rdy, 1);
            tick();
            check("stream_vld", a_ovld, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) check("stream_data", a_dout, sw[k-1]);
            check("stream_occ", a_occ, 2'((k < 3) + (k >= 1 && k <= 3)));
        end
        a_vld = 1'b0;

        // backpressure, DEPTH=3
        b_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_vld = 1'b1;
            b_din = bw[k];
            #1;
            check("bp_rdy_fill", b_rdy, 1);
            tick();
        end
        b_din = bw[3];
        #1;
        check("bp_rdy_full", b_rdy, 0);
        check("bp_occ_full", b_occ, 3);
        check("bp_head",     b_dout, bw[0]);
        b_ordy = 1'b1;
        #1;
        check("bp_rdy_release", b_rdy, 1);
        tick();
        b_vld = 1'b0;
        check("bp_out1", b_dout, bw[1]);
        check("bp_occ1", b_occ, 3);
        tick();
        check("bp_out2", b_dout, bw[2]);
        check("bp_occ2", b_occ, 2);
        tick();
        check("bp_out3", b_dout, bw[3]);
        check("bp_occ3", b_occ, 1);
        tick();
        check("bp_empty_vld", b_ovld, 0);
        check("bp_empty_occ", b_occ, 0);

        // bubble collapse, DEPTH=3
        b_ordy = 1'b0;
        b_vld = 1'b1; b_din = 32'h1234_5678;
        tick();
        b_vld = 1'b0;
        tick();
        b_vld = 1'b1; b_din = 32'h9ABC_DEF0;
        tick();
        b_vld = 1'b0;
        check("bub_occ_pre", b_occ, 2);
        check("bub_out_pre", b_dout, 32'h1234_5678);
        tick();
        check("bub_occ_post", b_occ, 2);
        check("bub_out_post", b_dout, 32'h1234_5678);
        #1;
        check("bub_rdy", b_rdy, 1);
        b_ordy = 1'b1;
        tick();
        check("bub_out_next", b_dout, 32'h9ABC_DEF0);
        check("bub_occ_next", b_occ, 1);
        tick();
        check("bub_drain", b_ovld, 0);

        // flush, DEPTH=3
        b_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_vld = 1'b1;
            b_din = bw[k];
            tick();
        end
        check("fl_occ_full", b_occ, 3);
        b_ordy = 1'b1; b_flush = 1'b1; b_din = bw[3];
        #1;
        check("fl_rdy", b_rdy, 0);
        tick();
        check("fl_occ", b_occ, 0);
        check("fl_vld", b_ovld, 0);
        check("fl_data", b_dout, 0);
        b_flush = 1'b0; b_vld = 1'b0;
        tick();
        check("fl_occ_after", b_occ, 0);
        check("fl_vld_after", b_ovld, 0);

        // share isolation, SHARES=3 WIDTH=8
        c_ordy = 1'b1;
        c_vld = 1'b1; c_din = 24'hA53CF0;
        tick();
        c_din = 24'h5AC30F;
        tick();
        c_vld = 1'b0;
        check("sh_data0", c_dout, 24'hA53CF0);
        check("sh_top0", c_dout[23:16], 8'hA5);
        tick();
        check("sh_data1", c_dout, 24'h5AC30F);
        tick();
        check("sh_drain", c_ovld, 0);

        // asynchronous reset with two words in flight, DEPTH=2
        a_ordy = 1'b0;
        a_vld = 1'b1; a_din = {32{4'hE}};
        tick();
        a_din = {32{4'hF}};
        tick();
        a_vld = 1'b0;
        check("ar_occ_pre", a_occ, 2);
        #3;
        rst = 1'b1;
        #1;
        check("ar_ovld", a_ovld, 0);
        check("ar_dout", a_dout, 0);
        check("ar_occ",  a_occ,  0);
        check("ar_rdy",  a_rdy,  1);
        #1;
        rst = 1'b0;
        a_ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ar_no_emit", a_ovld, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/share_pipe_stage.md
SHARE_PIPE_STAGE -- requirements
Module: share_pipe_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, bits per share.
REQ-002 The block SHALL have parameter SHARES, default 2, number of Boolean shares carried side by side.
REQ-003 The block SHALL have parameter DEPTH, default 2, number of register stages (legal range 1..8).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port flush  input  1  synchronous clear of all stages.
REQ-007 The block SHALL have port in_valid  input  1  in_data holds a word.
REQ-008 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data  input  SHARES*WIDTH  share s occupies bits [s*WIDTH +: WIDTH].
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a word.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 The block SHALL have port out_data  output  SHARES*WIDTH  same share layout as in_data.
REQ-013 The block SHALL have port occupancy  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold a valid bit v[i] and a data register d[i].
REQ-015 Ready chain SHALL be: r[DEPTH] = out_ready; r[i] = ~v[i] | r[i+1]; in_ready = r[0] & ~flush.
REQ-016 Stage 0 SHALL load in_data and set v[0] when in_valid & in_ready; stage i>0 SHALL load d[i-1] when v[i-1] & r[i].
REQ-017 A stage SHALL clear its valid bit when its word moves on and no new word enters it in the same cycle.
REQ-018 Bubbles SHALL collapse: an empty stage accepts from upstream even if out_ready=0.
REQ-019 Data registers SHALL change only on load or clear; stalled stages SHALL hold value and valid.
REQ-020 Latency SHALL be exactly DEPTH cycles from acceptance to out_valid when out_ready stays 1.
REQ-021 Throughput SHALL be one word per cycle when in_valid=1 and out_ready=1 continuously.
REQ-022 out_valid SHALL equal v[DEPTH-1]; out_data SHALL equal d[DEPTH-1], driven directly from the register.
REQ-023 Full (all v=1) with out_ready=0 SHALL force in_ready=0; with out_ready=1 the block SHALL accept and emit in the same cycle.
REQ-024 flush SHALL, on the next edge, clear all v[i] and zero all d[i]; it SHALL take priority over any accept or advance, and no word SHALL be accepted in a flush cycle.
REQ-025 occupancy SHALL equal the population count of v, updated with the registers.
REQ-026 Shares SHALL never be combined: no logic SHALL take bits of more than one share as inputs.
REQ-027 in_ready SHALL depend combinationally on out_ready and flush only through the ready chain; out_valid and out_data SHALL have no combinational path from any input.

Reset
REQ-028 Asserting rst SHALL immediately clear all v[i] and zero all d[i], regardless of clk.
REQ-029 During and after reset, out_valid=0, out_data=0, occupancy=0, and in_ready SHALL equal ~flush.
REQ-030 Reset mid-transfer SHALL discard all in-flight words; no partial word SHALL be emitted afterwards.

Structure
REQ-031 A shared package SHALL hold the share-slice helper (offset s*WIDTH), the occupancy width function, and the default WIDTH/SHARES constants.
REQ-032 One sub-module, share_pipe_cell, SHALL implement a single stage (valid bit, data register, load/clear control) and be instantiated DEPTH times.

Verification
REQ-033 Reset: assert rst asynchronously mid-cycle with 2 words in flight -> out_valid=0, out_data=0, occupancy=0 before the next edge.
REQ-034 Streaming: DEPTH=2, out_ready=1, push words 0x1111..., 0x2222..., 0x3333... back-to-back -> each appears on out_data 2 cycles later, in order, one per cycle.
REQ-035 Backpressure: DEPTH=3, out_ready=0, push 4 words -> first 3 accepted, in_ready=0 on 4th, occupancy=3; set out_ready=1 -> 4th accepted that same cycle, order preserved.
REQ-036 Bubble collapse: DEPTH=3, words in stages 0 and 2, out_ready=0 -> next edge moves stage-0 word to stage 1, occupancy stays 2.
REQ-037 Flush: full pipe, out_ready=1, in_valid=1, flush=1 -> no output consumed beyond that cycle, next cycle occupancy=0, all d[i]=0, new word not accepted.
REQ-038 Share isolation: SHARES=3, WIDTH=8, in_data=0xA5_3C_F0 -> out_data=0xA5_3C_F0 bit-exact after DEPTH cycles.
